// File: rtl/seg_value_driver.sv
// Binary-to-display driver for a bank of seven-segment decoders: hex pass-through or
// sequential double-dabble to BCD, with leading-zero blanking and overflow indication.
module seg_value_driver #(
  parameter int DIGITS = 8,
  parameter int BIN_W  = 27
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      in_value,
  input  logic                  in_hex,
  input  logic                  disp_en,
  output logic [4*DIGITS-1:0]   digit_o,
  output logic [DIGITS-1:0]     en_o,
  output logic                  ovf,
  output logic                  busy,
  output logic                  done
);

  localparam int DW    = 4 * DIGITS;
  localparam int SW    = DW + BIN_W;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIN_W - 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_CONV = 1'b1;

  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

  localparam logic [63:0] DEC_MAX = pow10_m1(DIGITS);

  // One double-dabble iteration over the combined {BCD, binary} shift register.
  function automatic logic [SW-1:0] dd_step(input logic [SW-1:0] v);
    logic [SW-1:0] a;
    a = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (a[BIN_W+4*i +: 4] >= 4'd5) a[BIN_W+4*i +: 4] = a[BIN_W+4*i +: 4] + 4'd3;
    end
    return a << 1;
  endfunction

  // Enable every digit up to the most significant nonzero one; digit 0 always shows.
  function automatic logic [DIGITS-1:0] lead_en(input logic [DW-1:0] d);
    logic [DIGITS-1:0] e;
    logic              seen;
    seen = 1'b0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      seen = seen | (d[4*i +: 4] != 4'd0);
      e[i] = seen;
    end
    e[0] = 1'b1;
    return e;
  endfunction

  logic [0:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic [DIGITS-1:0] raw_en;
  logic [SW-1:0]     dd;
  logic [SW-1:0]     dd_nxt;
  logic [DW-1:0]     bcd_fin;
  logic [63:0]       val_ext;
  logic [DW-1:0]     hex_dig;
  logic              hex_ovf;
  logic              dec_ovf;
  logic              accept;

  assign in_ready = (state == S_IDLE);
  assign busy     = (state == S_CONV);
  assign accept   = in_valid && in_ready;
  assign en_o     = raw_en & {DIGITS{disp_en}};

  assign val_ext  = 64'(in_value);
  assign hex_dig  = val_ext[DW-1:0];
  assign hex_ovf  = |(val_ext >> DW);
  assign dec_ovf  = (val_ext > DEC_MAX);

  assign dd_nxt   = dd_step(dd);
  assign bcd_fin  = dd_nxt[SW-1 -: DW];

  // Control and committed display registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      digit_o <= '0;
      raw_en  <= '0;
      ovf     <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (accept) begin
          if (in_hex) begin
            digit_o <= hex_dig;
            raw_en  <= hex_ovf ? '1 : lead_en(hex_dig);
            ovf     <= hex_ovf;
            done    <= 1'b1;
          end else if (dec_ovf) begin
            digit_o <= {DIGITS{4'hE}};
            raw_en  <= '1;
            ovf     <= 1'b1;
            done    <= 1'b1;
          end else begin
            state <= S_CONV;
            cnt   <= '0;
          end
        end
      end else begin
        if (cnt == LAST) begin
          state   <= S_IDLE;
          digit_o <= bcd_fin;
          raw_en  <= lead_en(bcd_fin);
          ovf     <= 1'b0;
          done    <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  // Conversion datapath; only meaningful while in CONV, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      dd <= {{DW{1'b0}}, in_value};
    end else if (busy) begin
      dd <= dd_nxt;
    end
  end

endmodule

// File: tb/tb_seg_value_driver.sv
// Self-checking bench for seg_value_driver: directed vector table, multi-cycle corner
// sequences, and randomized values against an arithmetic reference model.
module tb_seg_value_driver;

  localparam int DIGITS = 8;
  localparam int BIN_W  = 27;
  localparam int DW     = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [BIN_W-1:0]  in_value;
  logic              in_hex;
  logic              disp_en;
  logic [DW-1:0]     digit_o;
  logic [DIGITS-1:0] en_o;
  logic              ovf;
  logic              busy;
  logic              done;

  int checks   = 0;
  int failures = 0;

  seg_value_driver #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_value (in_value),
    .in_hex   (in_hex),
    .disp_en  (disp_en),
    .digit_o  (digit_o),
    .en_o     (en_o),
    .ovf      (ovf),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BIN_W-1:0]  v;
    logic              h;
    logic [DW-1:0]     d;
    logic [DIGITS-1:0] e;
    logic              o;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference: decimal digits by repeated division, hex digits by nibble extraction.
  task automatic model(input logic [63:0] v, input logic h,
                       output logic [DW-1:0] d, output logic [DIGITS-1:0] e, output logic o);
    logic [63:0] lim;
    logic [63:0] x;
    int          top;
    lim = 64'd1;
    for (int i = 0; i < DIGITS; i++) lim = lim * 64'd10;
    lim = lim - 64'd1;
    d = '0;
    o = 1'b0;
    if (h) begin
      for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = 4'((v >> (4*i)) & 64'hF);
      o = ((v >> DW) != 64'd0);
    end else if (v > lim) begin
      for (int i = 0; i < DIGITS; i++) d[4*i +: 4] = 4'hE;
      o = 1'b1;
    end else begin
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
        d[4*i +: 4] = 4'(x % 64'd10);
        x = x / 64'd10;
      end
    end
    top = 0;
    for (int i = 0; i < DIGITS; i++) if (d[4*i +: 4] != 4'd0) top = i;
    for (int i = 0; i < DIGITS; i++) e[i] = o ? 1'b1 : (i <= top);
  endtask

  task automatic wait_done(input string nm, output int j, output int busy_n);
    j = 0;
    busy_n = 0;
    while (j < 200) begin
      @(negedge clk);
      j++;
      if (busy) busy_n++;
      if (done) break;
    end
    chk({nm, "_latency"}, 64'(j), 64'(BIN_W + 1));
  endtask

  task automatic run(input logic [BIN_W-1:0] v, input logic h, input logic [DW-1:0] ed,
                     input logic [DIGITS-1:0] ee, input logic eo, input string nm);
    int j;
    int busy_n;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = v;
    in_hex   = h;
    @(posedge clk);
    #1 in_valid = 1'b0;
    if (h || eo) begin
      @(negedge clk);
      chk({nm, "_done"}, 64'(done), 64'd1);
      chk({nm, "_busy"}, 64'(busy), 64'd0);
    end else begin
      wait_done(nm, j, busy_n);
      chk({nm, "_busycycles"}, 64'(busy_n), 64'(BIN_W));
    end
    chk({nm, "_digit"}, 64'(digit_o), 64'(ed));
    chk({nm, "_en"}, 64'(en_o), 64'(ee));
    chk({nm, "_ovf"}, 64'(ovf), 64'(eo));
    @(negedge clk);
    chk({nm, "_donepulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0]     md;
    logic [DIGITS-1:0] me;
    logic              mo;
    logic [BIN_W-1:0]  rv;
    logic              rh;
    int                j;
    int                busy_n;
    int                dones;

    tbl[0] = '{27'd1234,      1'b0, 32'h00001234, 8'h0F, 1'b0};
    tbl[1] = '{27'h00ABCDE,   1'b1, 32'h000ABCDE, 8'h1F, 1'b0};
    tbl[2] = '{27'd0,         1'b0, 32'h00000000, 8'h01, 1'b0};
    tbl[3] = '{27'd0,         1'b1, 32'h00000000, 8'h01, 1'b0};
    tbl[4] = '{27'd99999999,  1'b0, 32'h99999999, 8'hFF, 1'b0};
    tbl[5] = '{27'd100000000, 1'b0, 32'hEEEEEEEE, 8'hFF, 1'b1};
    tbl[6] = '{27'h7FFFFFF,   1'b1, 32'h07FFFFFF, 8'h7F, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; in_value = '0; in_hex = 1'b0; disp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_digit", 64'(digit_o), 64'd0);
    chk("rst_en", 64'(en_o), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run(tbl[i].v, tbl[i].h, tbl[i].d, tbl[i].e, tbl[i].o, $sformatf("vec%0d", i));

    // Display enable gates only the enables, never the digits.
    @(negedge clk);
    disp_en = 1'b0;
    #1;
    chk("gate_en", 64'(en_o), 64'd0);
    chk("gate_digit", 64'(digit_o), 64'(tbl[6].d));
    disp_en = 1'b1;
    #1;
    chk("ungate_en", 64'(en_o), 64'(tbl[6].e));

    // 42 offered during the 5678 conversion is held off, then accepted afterwards.
    @(negedge clk);
    in_valid = 1'b1; in_value = 27'd5678; in_hex = 1'b0;
    @(posedge clk);
    #1 in_value = 27'd42;
    j = 0;
    while (j < 200) begin
      @(negedge clk);
      j++;
      if (j == 5) begin
        chk("bp_ready", 64'(in_ready), 64'd0);
        chk("bp_hold", 64'(digit_o), 64'(tbl[6].d));
      end
      if (done) break;
    end
    chk("bp_lat1", 64'(j), 64'(BIN_W + 1));
    chk("bp_digit1", 64'(digit_o), 64'h00005678);
    chk("bp_en1", 64'(en_o), 64'h0F);
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_done("bp2", j, busy_n);
    chk("bp_digit2", 64'(digit_o), 64'h00000042);
    chk("bp_en2", 64'(en_o), 64'h03);

    // Asynchronous reset mid-conversion aborts without a commit.
    @(negedge clk);
    in_valid = 1'b1; in_value = 27'd777; in_hex = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_digit", 64'(digit_o), 64'd0);
    chk("mid_rst_en", 64'(en_o), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_ovf", 64'(ovf), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    chk("mid_rst_nodone", 64'(dones), 64'd0);
    chk("mid_rst_hold", 64'(digit_o), 64'd0);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       rv = BIN_W'($urandom);
        1:       rv = BIN_W'($urandom_range(0, 9999));
        2:       rv = BIN_W'($urandom_range(99999990, 100000010));
        default: rv = BIN_W'($urandom_range(0, 99999999));
      endcase
      rh = 1'($urandom_range(0, 1));
      model(64'(rv), rh, md, me, mo);
      run(rv, rh, md, me, mo, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seg_value_driver.md
# seg_value_driver

Converts a binary value into per-digit nibbles and enables for a bank of seven-segment decoders (one 4-bit digit input plus one enable per decoder). Decimal mode uses a sequential double-dabble converter; hex mode passes the value through directly. Leading zeros are blanked, and an overflow indication is shown. Output registers are double-buffered, so the display never shows a partial conversion.

## Interface
- `DIGITS`, 8: number of display digits; legal range 1..8.
- `BIN_W`, 27: width of the binary input; legal range 1..32.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: a new value is offered.
- `in_ready` out 1: the block can accept a value; high only in IDLE.
- `in_value` in `BIN_W`: binary value.
- `in_hex` in 1: 1 = hex display, 0 = decimal display; sampled at accept.
- `disp_en` in 1: global display enable; gates `en_o` combinationally.
- `digit_o` out 4*`DIGITS`: nibble per digit; digit 0 = bits [3:0] = least significant.
- `en_o` out `DIGITS`: per-digit enable, already gated by `disp_en`.
- `ovf` out 1: displayed value is an overflow.
- `busy` out 1: a decimal conversion is in progress.
- `done` out 1: one-cycle pulse after the outputs update.

## Operation
- **Accept:** occurs on a rising edge where `in_valid && in_ready` (edge E0). `in_value` and `in_hex` are captured at E0.
- **States:** IDLE and CONV.
  - IDLE → CONV only for a decimal accept with no overflow.
  - CONV → IDLE on edge E0+`BIN_W`.
- **Hex mode:**
  - Committed at E0 with no CONV state.
  - `in_value` is zero-extended or truncated to 4*`DIGITS` bits.
  - `ovf` is 1 if any truncated bit is nonzero, else 0.
- **Decimal overflow:** if `in_value` > 10^`DIGITS`-1, the result is committed at E0 with no CONV state.
  - Every digit = 4'hE, all raw enables = 1, `ovf` = 1.
- **Decimal conversion (double-dabble):**
  - At E0, load the binary shift register and clear the BCD register.
  - Each CONV edge performs one iteration: every BCD digit ≥ 5 gets +3, then {BCD, bin} shifts left by 1.
  - Exactly `BIN_W` iterations run, on edges E0+1 .. E0+`BIN_W`.
  - The final iteration's result is written directly to the output registers with `ovf` = 0.
- **Leading-zero blanking** (non-overflow results only):
  - Raw enable[i] = 1 iff i ≤ index of the most significant nonzero digit.
  - Digit 0 is always enabled, so a value of 0 shows a single "0".
  - Blanked digits still drive nibble 0.
- **Output gating:** `en_o` = raw enable & {`DIGITS`{`disp_en`}}; `digit_o` is not gated.
- **Hold behaviour:** `digit_o`, raw enables and `ovf` hold their previous values throughout CONV and only change on a commit.
- **Back-pressure:** `in_valid` while `in_ready` = 0 is ignored and not queued; the upstream stage holds the value.
- **Reset (`rst_n` low):** asynchronous, including mid-conversion, which aborts the conversion with no commit.
  - State = IDLE.
  - `digit_o` = 0, raw enables = 0 (`en_o` = 0).
  - `ovf` = 0, `busy` = 0, `done` = 0, `in_ready` = 1.

## Timing
- `in_ready` = (state == IDLE), combinational from state.
- `busy` = (state == CONV).
- **Hex/overflow latency:** outputs are visible after E0; `done` is high for the cycle after E0; `in_ready` stays 1, so back-to-back accepts every cycle are legal.
- **Decimal latency:** `BIN_W` cycles (27 by default). Outputs are visible after E0+`BIN_W`, `done` is high for that cycle, and `in_ready` returns to 1 in the same cycle.
- **Throughput:** a new accept is legal on edge E0+`BIN_W`+1.
- `done` is registered and never held high for more than one cycle.

## Test plan
- **Reset, then decimal 1234** (`in_hex`=0, `disp_en`=1):
  - `busy` is high for 27 cycles.
  - Then `digit_o` = 32'h00001234, `en_o` = 8'b00001111, `ovf` = 0, and `done` pulses once.
- **Hex input 27'h00ABCDE:** after E0, `digit_o` = 32'h000ABCDE, `en_o` = 8'b00011111, `ovf` = 0, and no CONV state is entered.
- **Value 0, decimal and hex:** `digit_o` = 0, `en_o` = 8'b00000001.
- **Decimal boundary values:**
  - 99999999 → `digit_o` = 32'h99999999, `en_o` = 8'hFF, `ovf` = 0.
  - 100000000 → `digit_o` = 32'hEEEEEEEE, `en_o` = 8'hFF, `ovf` = 1, committed at E0.
- **Accept 5678, then 42 offered during CONV:**
  - 42 is ignored while `in_ready` = 0; outputs keep the old value until 5678 commits.
  - 42 is then accepted and commits 27 cycles later.
- **Reset and enable gating:**
  - Assert `rst_n`=0 at cycle 10 of a conversion: all outputs return to reset values immediately, and no `done` pulse occurs.
  - Toggle `disp_en`=0: `en_o` = 0 while `digit_o` is unchanged.
